// File: rtl/demo_stream_arbiter.sv
// Round-robin packet arbiter: one grant at a time, held to end of packet or MAX_BEATS.
// Latency: one arbitration cycle, then 1 beat/cycle; out_ready passes straight to req_ready[gnt].
module demo_stream_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_last,
  input  logic                        out_ready,
  output logic [$clog2(NUM_REQ)-1:0]  out_src,
  output logic                        busy,
  output logic                        trunc_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOCK = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gnt;
  logic [IDX_W-1:0] nxt_gnt;
  logic             nxt_found;
  logic [IDX_W:0]   cand;
  logic [CNT_W-1:0] beat_cnt;
  logic             lock;
  logic             accept;
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_data
    assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  // Search starts just past the last served requester so it ends up lowest priority.
  always_comb begin
    nxt_found = 1'b0;
    nxt_gnt   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!nxt_found && req_valid[cand[IDX_W-1:0]]) begin
        nxt_found = 1'b1;
        nxt_gnt   = cand[IDX_W-1:0];
      end
    end
  end

  // Reset gates the outputs so a grant disappears in the very cycle reset is raised.
  assign lock = (state == S_LOCK) && !rst;

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    req_ready = '0;
    out_src   = '0;
    busy      = 1'b0;
    if (lock) begin
      out_valid = req_valid[gnt];
      out_data  = data_arr[gnt];
      out_last  = req_last[gnt] || (beat_cnt == CNT_W'(MAX_BEATS - 1));
      out_src   = gnt;
      busy      = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        req_ready[i] = out_ready && (gnt == IDX_W'(i));
      end
    end
  end

  assign accept = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= IDX_W'(NUM_REQ - 1);
      gnt       <= '0;
      beat_cnt  <= '0;
      trunc_err <= 1'b0;
    end else if (state == S_IDLE) begin
      if (nxt_found) begin
        gnt   <= nxt_gnt;
        state <= S_LOCK;
      end
    end else if (accept) begin
      if (out_last) begin
        ptr      <= gnt;
        beat_cnt <= '0;
        state    <= S_IDLE;
        // A release without the requester's own last marker is a burst-limit cut.
        if (!req_last[gnt]) trunc_err <= 1'b1;
      end else begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

endmodule
